uram_read_gearbox: RTL and testbench
====================================

# uram_read_gearbox

Memclk-domain readout gearbox for the URAM event buffer.
- Takes 6-sample (72-bit) words read back from URAM, undoes the per-phase write scramble, and repacks every 4 words into 3 beats of 8 samples.
- Sits between the URAM read port and the event readout path.
- Is the read-side inverse of the aclk→memclk write transfer.

## Interface
- NSAMP, 8: samples per output beat; must be a multiple of 4.
- NBIT, 12: bits per sample.
- memclk_i  in  1  memory clock; sole clock.
- memclk_rst_i  in  1  reset, synchronous, active-high.
- dat_i  in  NSAMP*3/4*NBIT  URAM read word.
- dat_valid_i  in  1  dat_i valid.
- dat_first_i  in  1  qualifies dat_i as word 0 of a 4-word group.
- dat_ready_o  out  1  word accepted when dat_valid_i & dat_ready_o.
- dat_o  out  NSAMP*NBIT  output beat; sample 0 in the LSBs.
- dat_valid_o  out  1  dat_o valid.
- dat_ready_i  in  1  downstream accept.
- align_err_o  out  1  one-cycle pulse on group misalignment.

## Operation
- Chunk definitions:
  - Chunk = NSAMP/4 samples = 2*NBIT bits for NSAMP=8.
  - A word holds chunks c0 (LSBs), c1, c2.
- Word counter wcnt (2 bits) tracks word index within the group.
  - It increments on each accepted word and wraps 3→0.
- Unscramble by wcnt (output chunks listed c0,c1,c2):
  - w0: identity.
  - w1: c1,c0,c2.
  - w2: c2,c1,c0.
  - w3: c1,c2,c0.
- Repack, where u = unscrambled word and R = residual register (max 6 samples):
  - w0: R←u; no output.
  - w1: beat={u.c0,R}; R←{u.c2,u.c1}.
  - w2: beat={u.c1,u.c0,R[4 samples]}; R←u.c2.
  - w3: beat={u,R[2 samples]}; R cleared.
- Alignment:
  - An accepted word with dat_first_i=1 while wcnt≠0 pulses align_err_o for one cycle.
  - That word is treated as w0: R is overwritten and the partial group is discarded.
  - dat_first_i=1 at wcnt=0 is normal.
  - dat_first_i=0 at wcnt=0 is accepted as w0 with no error (free-running groups).
- Handshake:
  - dat_ready_o = !dat_valid_o | dat_ready_i.
  - The output register is loaded only on w1/w2/w3 accepts.
  - dat_valid_o clears when dat_ready_i is high and no new beat is loaded.
  - A beat is held stable while dat_valid_o & !dat_ready_i.
- Reset values:
  - dat_o=0, dat_valid_o=0, align_err_o=0.
  - wcnt=0, R=0.
  - dat_ready_o=1 the cycle after reset.

## Timing
- Latency: accepted w1/w2/w3 word → dat_valid_o high on the next memclk edge.
- Throughput: with dat_ready_i held high, 1 word/clk in gives 3 beats per 4 clocks out. No internal bubbles.
- Backpressure: dat_ready_o depends combinationally on dat_ready_i. There is no skid buffer.
- Reset mid-group: asserting memclk_rst_i discards R and wcnt. The next word is w0.
- Simultaneous output drain and load: the new beat replaces the old one in the same cycle, and dat_valid_o stays high.

## Configuration
- URAM_READ_UNSCRAMBLE_EN
  - Defined: the per-wcnt chunk permutation above is applied. This pairs with writers built with scramble enabled.
  - Undefined: u = dat_i for all wcnt (pure 6→8 gearbox), for writers with scramble disabled. Repacking, handshake, and latency are unchanged.

## Structure
- Package uram_pkg holds:
  - localparams NSAMP_MEM = NSAMP*3/4 and CHUNK_BITS = NSAMP/4*NBIT.
  - typedef for the 2-bit word index.
  - enum W0..W3.
- Sub-module uram_read_unscramble: combinational chunk permutation selected by word index. It is wrapped by the macro.
- The top level holds wcnt, R, the output register, and the handshake logic.

## Test plan
- Group decode:
  - Stimulus: sample s = index, 0x000–0x017, written by the reference scramble model into 4 words; dat_ready_i=1; dat_first_i on word 0.
  - Expected: beats 0x000–0x007, 0x008–0x00F, 0x010–0x017 at clocks 2, 3, 4 after the first accept.
- Continuous stream:
  - Stimulus: 12 back-to-back words.
  - Expected: 9 beats, with exactly one idle output cycle per group.
- Backpressure:
  - Stimulus: hold dat_ready_i=0 for 5 cycles mid-group.
  - Expected: dat_o stable, dat_ready_o=0, no sample lost or duplicated.
- Misalignment:
  - Stimulus: dat_first_i on the 3rd word of a group.
  - Expected: align_err_o pulses once; the next output is {new w1.c0, new w0}; the old partial samples are never emitted.
- Reset mid-group:
  - Stimulus: memclk_rst_i after 2 words.
  - Expected: dat_valid_o=0 and R=0; the next 4 words decode cleanly with no error.
- Macro off:
  - Stimulus: identical unscrambled input.
  - Expected: the same beats. With the macro on, scrambled input w2 = {0x010..} decodes correctly only when the macro is defined.

Source files
------------

// File: rtl/uram_read_gearbox_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uram_pkg
//  Description : Shared widths, word-index type and word enum for the URAM
//                readout gearbox.
//  Revision    : 1.0 - initial release
// ============================================================================
package uram_pkg;

  localparam int c_DEF_NSAMP = 8;
  localparam int c_DEF_NBIT  = 12;

  localparam int NSAMP_MEM  = c_DEF_NSAMP * 3 / 4;
  localparam int CHUNK_BITS = c_DEF_NSAMP / 4 * c_DEF_NBIT;

  typedef logic [1:0] widx_t;

  typedef enum logic [1:0] {
    W0 = 2'd0,
    W1 = 2'd1,
    W2 = 2'd2,
    W3 = 2'd3
  } widx_e;

  function automatic widx_t widx_next(input widx_t w);
    return w + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uram_read_unscramble.sv
`default_nettype none
// ============================================================================
//  Module      : uram_read_unscramble
//  Description : Combinational per-word chunk permutation that undoes the
//                write-side scramble; chunk c0 sits in the LSBs.
//  Revision    : 1.0 - initial release
// ============================================================================
module uram_read_unscramble
  import uram_pkg::*;
#(
  parameter int CW = CHUNK_BITS
) (
  input  logic [3*CW-1:0] i_word,
  input  widx_t           i_widx,
  output logic [3*CW-1:0] o_word
);

  logic [CW-1:0] w_c0;
  logic [CW-1:0] w_c1;
  logic [CW-1:0] w_c2;

  assign w_c0 = i_word[CW-1:0];
  assign w_c1 = i_word[2*CW-1:CW];
  assign w_c2 = i_word[3*CW-1:2*CW];

  // Concatenations are MSB-first, so each reads as {out.c2, out.c1, out.c0}.
  always_comb begin
    o_word = i_word;
    case (widx_e'(i_widx))
      W0: o_word = i_word;
      W1: o_word = {w_c2, w_c0, w_c1};
      W2: o_word = {w_c0, w_c1, w_c2};
      W3: o_word = {w_c0, w_c2, w_c1};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/uram_read_gearbox.sv
`default_nettype none
// ============================================================================
//  Module      : uram_read_gearbox
//  Description : Unscrambles 3-chunk URAM words and repacks 4 words into
//                3 output beats. Macro URAM_READ_UNSCRAMBLE_EN enables the
//                chunk permutation; undefined gives a pure 6->8 gearbox.
//  Revision    : 1.0 - initial release
// ============================================================================
module uram_read_gearbox
  import uram_pkg::*;
#(
  parameter int NSAMP = 8,
  parameter int NBIT  = 12
) (
  input  logic                    memclk_i,
  input  logic                    memclk_rst_i,
  input  logic [NSAMP*3/4*NBIT-1:0] dat_i,
  input  logic                    dat_valid_i,
  input  logic                    dat_first_i,
  output logic                    dat_ready_o,
  output logic [NSAMP*NBIT-1:0]   dat_o,
  output logic                    dat_valid_o,
  input  logic                    dat_ready_i,
  output logic                    align_err_o
);

  localparam int c_CW = NSAMP / 4 * NBIT;
  localparam int c_WW = 3 * c_CW;
  localparam int c_BW = NSAMP * NBIT;

  widx_t             r_wcnt;
  logic [c_WW-1:0]   r_resid;
  logic [c_BW-1:0]   r_dat;
  logic              r_valid;
  logic              r_err;

  logic              w_accept;
  logic              w_misalign;
  logic              w_load;
  widx_e             w_idx;
  logic [c_WW-1:0]   w_unscr;
  logic [c_WW-1:0]   w_resid_nxt;
  logic [c_BW-1:0]   w_beat;

  assign dat_ready_o = !r_valid | dat_ready_i;
  assign dat_o       = r_dat;
  assign dat_valid_o = r_valid;
  assign align_err_o = r_err;

  assign w_accept   = dat_valid_i & dat_ready_o;
  // A first-flagged word always restarts the group, discarding any partial one.
  assign w_idx      = dat_first_i ? W0 : widx_e'(r_wcnt);
  assign w_misalign = w_accept & dat_first_i & (r_wcnt != 2'd0);

`ifdef URAM_READ_UNSCRAMBLE_EN
  uram_read_unscramble #(
    .CW (c_CW)
  ) u_unscramble (
    .i_word (dat_i),
    .i_widx (widx_t'(w_idx)),
    .o_word (w_unscr)
  );
`else
  assign w_unscr = dat_i;
`endif

  // Residual holds 3, 2, 1, 0 leftover chunks after words 0..3 respectively.
  always_comb begin
    w_beat      = '0;
    w_resid_nxt = r_resid;
    w_load      = 1'b0;
    case (w_idx)
      W0: begin
        w_resid_nxt = w_unscr;
      end
      W1: begin
        w_beat      = {w_unscr[c_CW-1:0], r_resid};
        w_resid_nxt = {{c_CW{1'b0}}, w_unscr[c_WW-1:c_CW]};
        w_load      = 1'b1;
      end
      W2: begin
        w_beat      = {w_unscr[2*c_CW-1:0], r_resid[2*c_CW-1:0]};
        w_resid_nxt = {{(2*c_CW){1'b0}}, w_unscr[c_WW-1:2*c_CW]};
        w_load      = 1'b1;
      end
      W3: begin
        w_beat      = {w_unscr, r_resid[c_CW-1:0]};
        w_resid_nxt = '0;
        w_load      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge memclk_i) begin
    if (memclk_rst_i) begin
      r_wcnt  <= '0;
      r_resid <= '0;
      r_dat   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_misalign;
      if (w_accept) begin
        r_wcnt  <= widx_next(widx_t'(w_idx));
        r_resid <= w_resid_nxt;
      end
      if (w_accept && w_load) begin
        r_dat   <= w_beat;
        r_valid <= 1'b1;
      end else if (dat_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uram_read_gearbox.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uram_read_gearbox
//  Description : Directed self-checking bench for uram_read_gearbox.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uram_read_gearbox;

  localparam int c_NSAMP = 8;
  localparam int c_NBIT  = 12;
  localparam int c_WW    = c_NSAMP * 3 / 4 * c_NBIT;
  localparam int c_BW    = c_NSAMP * c_NBIT;
  localparam int c_CW    = c_NSAMP / 4 * c_NBIT;

  logic            memclk_i = 1'b0;
  logic            memclk_rst_i = 1'b1;
  logic [c_WW-1:0] dat_i = '0;
  logic            dat_valid_i = 1'b0;
  logic            dat_first_i = 1'b0;
  logic            dat_ready_o;
  logic [c_BW-1:0] dat_o;
  logic            dat_valid_o;
  logic            dat_ready_i = 1'b1;
  logic            align_err_o;

  int n_tests = 0;
  int n_fail  = 0;
  int err_pulses = 0;
  logic [c_BW-1:0] got[$];

  uram_read_gearbox #(.NSAMP(c_NSAMP), .NBIT(c_NBIT)) dut (
    .memclk_i     (memclk_i),
    .memclk_rst_i (memclk_rst_i),
    .dat_i        (dat_i),
    .dat_valid_i  (dat_valid_i),
    .dat_first_i  (dat_first_i),
    .dat_ready_o  (dat_ready_o),
    .dat_o        (dat_o),
    .dat_valid_o  (dat_valid_o),
    .dat_ready_i  (dat_ready_i),
    .align_err_o  (align_err_o)
  );

  always #5 memclk_i = ~memclk_i;

  always @(negedge memclk_i) begin
    if (!memclk_rst_i && dat_valid_o && dat_ready_i) got.push_back(dat_o);
    if (align_err_o) err_pulses++;
  end

  function automatic logic [c_WW-1:0] seq_word(input int base);
    logic [c_WW-1:0] w = '0;
    for (int i = 0; i < 6; i++) w[i*c_NBIT +: c_NBIT] = 12'(base + i);
    return w;
  endfunction

  function automatic logic [c_BW-1:0] seq_beat(input int base);
    logic [c_BW-1:0] b = '0;
    for (int i = 0; i < 8; i++) b[i*c_NBIT +: c_NBIT] = 12'(base + i);
    return b;
  endfunction

  // Writer-side scramble: the word the URAM holds for unscrambled content u.
  function automatic logic [c_WW-1:0] scr(input logic [c_WW-1:0] u, input int idx);
    logic [c_CW-1:0] u0, u1, u2;
    u0 = u[c_CW-1:0];
    u1 = u[2*c_CW-1:c_CW];
    u2 = u[3*c_CW-1:2*c_CW];
`ifdef URAM_READ_UNSCRAMBLE_EN
    case (idx)
      1: return {u2, u0, u1};
      2: return {u0, u1, u2};
      3: return {u1, u0, u2};
      default: return u;
    endcase
`else
    return {u2, u1, u0} | c_WW'(idx & 0);
`endif
  endfunction

  function automatic logic [c_WW-1:0] grp_word(input int base, input int idx);
    return scr(seq_word(base + 6 * idx), idx);
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge memclk_i); #1;
    end
  endtask

  task automatic drive_word(input logic [c_WW-1:0] w, input logic first);
    int n = 0;
    dat_i = w; dat_first_i = first; dat_valid_i = 1'b1;
    @(negedge memclk_i);
    while (!dat_ready_o && n < 50) begin
      n++;
      @(negedge memclk_i);
    end
    n_tests++;
    if (!dat_ready_o) begin
      n_fail++;
      $display("FAIL accept_timeout: dat_ready_o=%b required 1 within 50 cycles", dat_ready_o);
    end
    @(posedge memclk_i); #1;
    dat_valid_i = 1'b0; dat_first_i = 1'b0;
  endtask

  task automatic test_reset();
    memclk_rst_i = 1'b1;
    idle(3);
    memclk_rst_i = 1'b0;
    #1;
    n_tests++; if (dat_o !== '0) begin n_fail++; $display("FAIL reset_dat: got %h required 0", dat_o); end
    n_tests++; if (dat_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", dat_valid_o); end
    n_tests++; if (align_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", align_err_o); end
    n_tests++; if (dat_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", dat_ready_o); end
  endtask

  task automatic test_group_decode();
    int base = 'h000;
    drive_word(grp_word(base, 0), 1'b1);
    n_tests++; if (dat_valid_o !== 1'b0) begin n_fail++; $display("FAIL gd_w0_valid: got %b required 0", dat_valid_o); end
    for (int k = 1; k < 4; k++) begin
      drive_word(grp_word(base, k), 1'b0);
      n_tests++; if (dat_valid_o !== 1'b1) begin n_fail++; $display("FAIL gd_valid_w%0d: got %b required 1", k, dat_valid_o); end
      n_tests++; if (dat_o !== seq_beat(base + 8 * (k - 1))) begin n_fail++; $display("FAIL gd_beat%0d: got %h required %h", k - 1, dat_o, seq_beat(base + 8 * (k - 1))); end
    end
    idle(1);
    n_tests++; if (dat_valid_o !== 1'b0) begin n_fail++; $display("FAIL gd_drain: got %b required 0", dat_valid_o); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    int base = 'h300;
    got.delete();
    for (int i = 0; i < 12; i++) begin
      drive_word(grp_word(base + 24 * (i / 4), i % 4), (i % 4) == 0);
      n_tests++; if (dat_valid_o !== ((i % 4) != 0)) begin n_fail++; $display("FAIL b2b_valid%0d: got %b required %b", i, dat_valid_o, (i % 4) != 0); end
    end
    idle(3);
    n_tests++; if (got.size() != 9) begin n_fail++; $display("FAIL b2b_count: got %0d required 9", got.size()); end
    for (int k = 0; k < 9; k++) begin
      n_tests++; if (got[k] !== seq_beat(base + 8 * k)) begin n_fail++; $display("FAIL b2b_beat%0d: got %h required %h", k, got[k], seq_beat(base + 8 * k)); end
    end
  endtask

  task automatic test_backpressure();
    int base = 'h500;
    got.delete();
    drive_word(grp_word(base, 0), 1'b1);
    drive_word(grp_word(base, 1), 1'b0);
    dat_ready_i = 1'b0;
    dat_i = grp_word(base, 2); dat_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge memclk_i);
      n_tests++; if (dat_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d: got %b required 0", c, dat_ready_o); end
      n_tests++; if (dat_o !== seq_beat(base) || dat_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_hold%0d: got %h/%b required %h/1", c, dat_o, dat_valid_o, seq_beat(base)); end
    end
    @(posedge memclk_i); #1;
    dat_ready_i = 1'b1;
    drive_word(grp_word(base, 2), 1'b0);
    n_tests++; if (dat_valid_o !== 1'b1 || dat_o !== seq_beat(base + 8)) begin n_fail++; $display("FAIL bp_replace: got %h/%b required %h/1", dat_o, dat_valid_o, seq_beat(base + 8)); end
    drive_word(grp_word(base, 3), 1'b0);
    idle(3);
    n_tests++; if (got.size() != 3) begin n_fail++; $display("FAIL bp_count: got %0d required 3", got.size()); end
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (got[k] !== seq_beat(base + 8 * k)) begin n_fail++; $display("FAIL bp_beat%0d: got %h required %h", k, got[k], seq_beat(base + 8 * k)); end
    end
  endtask

  task automatic test_misalign();
    int a = 'h600;
    int b = 'h700;
    got.delete();
    err_pulses = 0;
    drive_word(grp_word(a, 0), 1'b1);
    drive_word(grp_word(a, 1), 1'b0);
    drive_word(grp_word(b, 0), 1'b1);
    n_tests++; if (align_err_o !== 1'b1) begin n_fail++; $display("FAIL mis_err: got %b required 1", align_err_o); end
    drive_word(grp_word(b, 1), 1'b0);
    n_tests++; if (align_err_o !== 1'b0) begin n_fail++; $display("FAIL mis_err_clear: got %b required 0", align_err_o); end
    n_tests++; if (dat_o !== seq_beat(b) || dat_valid_o !== 1'b1) begin n_fail++; $display("FAIL mis_first_beat: got %h/%b required %h/1", dat_o, dat_valid_o, seq_beat(b)); end
    drive_word(grp_word(b, 2), 1'b0);
    drive_word(grp_word(b, 3), 1'b0);
    idle(3);
    n_tests++; if (err_pulses != 1) begin n_fail++; $display("FAIL mis_pulses: got %0d required 1", err_pulses); end
    n_tests++; if (got.size() != 4) begin n_fail++; $display("FAIL mis_count: got %0d required 4", got.size()); end
    n_tests++; if (got[0] !== seq_beat(a)) begin n_fail++; $display("FAIL mis_old_beat: got %h required %h", got[0], seq_beat(a)); end
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (got[k + 1] !== seq_beat(b + 8 * k)) begin n_fail++; $display("FAIL mis_new_beat%0d: got %h required %h", k, got[k + 1], seq_beat(b + 8 * k)); end
    end
  endtask

  task automatic test_reset_mid_group();
    int c = 'h800;
    int d = 'h900;
    drive_word(grp_word(c, 0), 1'b1);
    drive_word(grp_word(c, 1), 1'b0);
    memclk_rst_i = 1'b1;
    idle(1);
    memclk_rst_i = 1'b0;
    n_tests++; if (dat_valid_o !== 1'b0 || dat_o !== '0) begin n_fail++; $display("FAIL rst_mid_out: got %h/%b required 0/0", dat_o, dat_valid_o); end
    n_tests++; if (dut.r_resid !== '0) begin n_fail++; $display("FAIL rst_mid_resid: got %h required 0", dut.r_resid); end
    got.delete();
    err_pulses = 0;
    for (int k = 0; k < 4; k++) drive_word(grp_word(d, k), 1'b0);
    idle(3);
    n_tests++; if (err_pulses != 0) begin n_fail++; $display("FAIL rst_mid_err: got %0d required 0", err_pulses); end
    n_tests++; if (got.size() != 3) begin n_fail++; $display("FAIL rst_mid_count: got %0d required 3", got.size()); end
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (got[k] !== seq_beat(d + 8 * k)) begin n_fail++; $display("FAIL rst_mid_beat%0d: got %h required %h", k, got[k], seq_beat(d + 8 * k)); end
    end
  endtask

  // Sequential (unscrambled) words: identity gearbox without the macro,
  // a fixed hand-derived sample order with it.
  task automatic test_raw_words();
    int base = 'hA00;
    int idx[24];
    logic [c_BW-1:0] exp_b;
`ifdef URAM_READ_UNSCRAMBLE_EN
    idx = '{0, 1, 2, 3, 4, 5, 8, 9,
            6, 7, 10, 11, 16, 17, 14, 15,
            12, 13, 20, 21, 22, 23, 18, 19};
`else
    for (int i = 0; i < 24; i++) idx[i] = i;
`endif
    got.delete();
    for (int k = 0; k < 4; k++) drive_word(seq_word(base + 6 * k), k == 0);
    idle(3);
    n_tests++; if (got.size() != 3) begin n_fail++; $display("FAIL raw_count: got %0d required 3", got.size()); end
    for (int k = 0; k < 3; k++) begin
      exp_b = '0;
      for (int j = 0; j < 8; j++) exp_b[j*c_NBIT +: c_NBIT] = 12'(base + idx[8*k + j]);
      n_tests++; if (got[k] !== exp_b) begin n_fail++; $display("FAIL raw_beat%0d: got %h required %h", k, got[k], exp_b); end
    end
  endtask

  initial begin
    test_reset();
    test_group_decode();
    test_back_to_back();
    test_backpressure();
    test_misalign();
    test_reset_mid_group();
    test_raw_words();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
